// File: rtl/hvac_zone_scheduler.sv
// hvac_zone_scheduler: shares one heat/cool plant between four thermostat zones.
// Chooses the plant mode, grants one zone's damper at a time, enforces minimum
// on/off times, and rotates same-mode zones on a MAX_RUN time slice.
module hvac_zone_scheduler #(
    parameter int MIN_ON  = 8,
    parameter int MIN_OFF = 4,
    parameter int MAX_RUN = 32,
    parameter int TW      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] heat_req,
    input  logic [3:0] cool_req,
    output logic       heating,
    output logic       cooling,
    output logic [3:0] damper,
    output logic [1:0] zone_id,
    output logic [1:0] state_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_HEAT = 2'b01,
        S_COOL = 2'b10,
        S_LOCK = 2'b11
    } state_t;

    localparam logic [TW-1:0] MIN_ON_M1  = TW'(MIN_ON - 1);
    localparam logic [TW-1:0] MIN_OFF_M1 = TW'(MIN_OFF - 1);
    localparam logic [TW-1:0] MAX_RUN_M1 = TW'(MAX_RUN - 1);

    // First requesting zone after p in rotation order; p itself is tried last.
    function automatic logic [1:0] rr_pick(input logic [1:0] p, input logic [3:0] v);
        logic [1:0] idx;
        rr_pick = p;
        for (int k = 4; k >= 1; k--) begin
            idx = p + 2'(k);
            if (v[idx]) rr_pick = idx;
        end
    endfunction

    function automatic logic [3:0] onehot(input logic [1:0] i);
        onehot = 4'b0001 << i;
    endfunction

    state_t        state_q, state_d;
    logic [TW-1:0] run_cnt_q, run_cnt_d;
    logic [TW-1:0] off_cnt_q, off_cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic          last_mode_q, last_mode_d;
    logic [1:0]    zone_id_q, zone_id_d;
    logic          heating_q, heating_d;
    logic          cooling_q, cooling_d;
    logic [3:0]    damper_q, damper_d;

    // Zones asking for both modes at once are treated as not asking at all.
    logic [3:0] hv, cv, mode_vec, others;
    logic       min_met, at_max;

    assign hv       = heat_req & ~cool_req;
    assign cv       = cool_req & ~heat_req;
    assign mode_vec = (state_q == S_COOL) ? cv : hv;
    assign others   = mode_vec & ~onehot(ptr_q);
    assign min_met  = (run_cnt_q >= MIN_ON_M1);
    assign at_max   = (run_cnt_q == MAX_RUN_M1);

    // Next-state, counter, grant and registered-output computation.
    always_comb begin
        state_d     = state_q;
        run_cnt_d   = run_cnt_q;
        off_cnt_d   = off_cnt_q;
        ptr_d       = ptr_q;
        last_mode_d = last_mode_q;
        zone_id_d   = zone_id_q;

        unique case (state_q)
            S_IDLE: begin
                if (hv != 4'b0 && (cv == 4'b0 || last_mode_q)) begin
                    state_d     = S_HEAT;
                    ptr_d       = rr_pick(ptr_q, hv);
                    zone_id_d   = rr_pick(ptr_q, hv);
                    last_mode_d = 1'b0;
                    run_cnt_d   = '0;
                end else if (cv != 4'b0) begin
                    state_d     = S_COOL;
                    ptr_d       = rr_pick(ptr_q, cv);
                    zone_id_d   = rr_pick(ptr_q, cv);
                    last_mode_d = 1'b1;
                    run_cnt_d   = '0;
                end
            end
            S_HEAT, S_COOL: begin
                // Opposite-mode requests are never served from here; a mode
                // change always goes through LOCK and IDLE.
                if (min_met && !mode_vec[ptr_q]) begin
                    if (others != 4'b0) begin
                        ptr_d     = rr_pick(ptr_q, others);
                        zone_id_d = rr_pick(ptr_q, others);
                        run_cnt_d = '0;
                    end else begin
                        state_d   = S_LOCK;
                        off_cnt_d = '0;
                    end
                end else if (at_max && others != 4'b0) begin
                    ptr_d     = rr_pick(ptr_q, others);
                    zone_id_d = rr_pick(ptr_q, others);
                    run_cnt_d = '0;
                end else if (!at_max) begin
                    run_cnt_d = run_cnt_q + TW'(1);
                end
            end
            S_LOCK: begin
                if (off_cnt_q == MIN_OFF_M1) begin
                    state_d = S_IDLE;
                end else begin
                    off_cnt_d = off_cnt_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        heating_d = (state_d == S_HEAT);
        cooling_d = (state_d == S_COOL);
        damper_d  = (state_d == S_HEAT || state_d == S_COOL) ? onehot(ptr_d) : 4'b0;
    end

    // State and output registers; reset leaves the plant off with zone 0 next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            run_cnt_q   <= '0;
            off_cnt_q   <= '0;
            ptr_q       <= 2'd3;
            last_mode_q <= 1'b1;
            zone_id_q   <= 2'd0;
            heating_q   <= 1'b0;
            cooling_q   <= 1'b0;
            damper_q    <= 4'b0;
        end else begin
            state_q     <= state_d;
            run_cnt_q   <= run_cnt_d;
            off_cnt_q   <= off_cnt_d;
            ptr_q       <= ptr_d;
            last_mode_q <= last_mode_d;
            zone_id_q   <= zone_id_d;
            heating_q   <= heating_d;
            cooling_q   <= cooling_d;
            damper_q    <= damper_d;
        end
    end

    assign heating = heating_q;
    assign cooling = cooling_q;
    assign damper  = damper_q;
    assign zone_id = zone_id_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_hvac_zone_scheduler.sv
// Scoreboard testbench for hvac_zone_scheduler: the stimulus process queues the
// hand-computed output expected after each clock edge, the monitor pops and
// compares on the falling edge.
module tb_hvac_zone_scheduler;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HEAT = 2'b01;
    localparam logic [1:0] ST_COOL = 2'b10;
    localparam logic [1:0] ST_LOCK = 2'b11;

    logic       clk;
    logic       reset;
    logic [3:0] heat_req;
    logic [3:0] cool_req;
    logic       heating;
    logic       cooling;
    logic [3:0] damper;
    logic [1:0] zone_id;
    logic [1:0] state_o;

    typedef struct packed {
        logic [1:0] st;
        logic       he;
        logic       co;
        logic [3:0] dm;
        logic [1:0] zid;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    checks = 0;
    int    errors = 0;

    hvac_zone_scheduler #(
        .MIN_ON (8),
        .MIN_OFF(4),
        .MAX_RUN(32),
        .TW     (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .heat_req(heat_req),
        .cool_req(cool_req),
        .heating (heating),
        .cooling (cooling),
        .damper  (damper),
        .zone_id (zone_id),
        .state_o (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive n cycles of the same inputs, each expecting the same post-edge output.
    task automatic cyc(input int n, input logic rst, input logic [3:0] h, input logic [3:0] c,
                       input logic [1:0] st, input logic he, input logic co,
                       input logic [3:0] dm, input logic [1:0] zid, input string tag);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            reset    = rst;
            heat_req = h;
            cool_req = c;
            e.st  = st;
            e.he  = he;
            e.co  = co;
            e.dm  = dm;
            e.zid = zid;
            exp_q.push_back(e);
            tag_q.push_back(tag);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        cyc(2, 1'b1, 4'b0000, 4'b0000, ST_IDLE, 1'b0, 1'b0, 4'b0000, 2'd0, "reset_state");
    endtask

    // Monitor: one expected entry per clock, compared away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (state_o !== e.st || heating !== e.he || cooling !== e.co ||
                damper !== e.dm || zone_id !== e.zid) begin
                errors++;
                $display("FAIL %s t=%0t: got st=%b heat=%b cool=%b damper=%b zone=%0d, want st=%b heat=%b cool=%b damper=%b zone=%0d",
                         t, $time, state_o, heating, cooling, damper, zone_id,
                         e.st, e.he, e.co, e.dm, e.zid);
            end
        end
    end

    initial begin
        reset    = 1'b1;
        heat_req = 4'b0;
        cool_req = 4'b0;

        // Single heat run: exactly MIN_ON heating cycles, MIN_OFF lockout, idle.
        do_reset();
        cyc(3, 1'b0, 4'b0001, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0001, 2'd0, "a_heat_req");
        cyc(5, 1'b0, 4'b0000, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0001, 2'd0, "a_min_on");
        cyc(4, 1'b0, 4'b0000, 4'b0000, ST_LOCK, 1'b0, 1'b0, 4'b0000, 2'd0, "a_lockout");
        cyc(2, 1'b0, 4'b0000, 4'b0000, ST_IDLE, 1'b0, 1'b0, 4'b0000, 2'd0, "a_idle");

        // Tie-break: heat first, then cool after lockout plus one idle cycle.
        do_reset();
        cyc(10, 1'b0, 4'b0010, 4'b0100, ST_HEAT, 1'b1, 1'b0, 4'b0010, 2'd1, "b_heat_first");
        cyc(4, 1'b0, 4'b0000, 4'b0100, ST_LOCK, 1'b0, 1'b0, 4'b0000, 2'd1, "b_lockout");
        cyc(1, 1'b0, 4'b0000, 4'b0100, ST_IDLE, 1'b0, 1'b0, 4'b0000, 2'd1, "b_idle_gap");
        cyc(3, 1'b0, 4'b0000, 4'b0100, ST_COOL, 1'b0, 1'b1, 4'b0100, 2'd2, "b_cool");

        // Time slice rotation 0 -> 1 -> 3 -> 0 with heating held.
        do_reset();
        cyc(32, 1'b0, 4'b1011, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0001, 2'd0, "c_slice_z0");
        cyc(32, 1'b0, 4'b1011, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0010, 2'd1, "c_slice_z1");
        cyc(32, 1'b0, 4'b1011, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b1000, 2'd3, "c_slice_z3");
        cyc(2, 1'b0, 4'b1011, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0001, 2'd0, "c_slice_wrap");

        // Conflicting requests on one zone are ignored.
        do_reset();
        cyc(10, 1'b0, 4'b0100, 4'b0100, ST_IDLE, 1'b0, 1'b0, 4'b0000, 2'd0, "d_conflict");

        // Handoff when granted zone drops early; new zone restarts MIN_ON.
        do_reset();
        cyc(3, 1'b0, 4'b0011, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0001, 2'd0, "e_both");
        cyc(5, 1'b0, 4'b0010, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0001, 2'd0, "e_hold_z0");
        cyc(1, 1'b0, 4'b0010, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0010, 2'd1, "e_handoff");
        cyc(7, 1'b0, 4'b0000, 4'b0000, ST_HEAT, 1'b1, 1'b0, 4'b0010, 2'd1, "e_z1_min_on");
        cyc(4, 1'b0, 4'b0000, 4'b0000, ST_LOCK, 1'b0, 1'b0, 4'b0000, 2'd1, "e_lockout");
        cyc(1, 1'b0, 4'b0000, 4'b0000, ST_IDLE, 1'b0, 1'b0, 4'b0000, 2'd1, "e_idle");

        // Reset during a cool run, then immediate restart without lockout.
        do_reset();
        cyc(4, 1'b0, 4'b0000, 4'b0100, ST_COOL, 1'b0, 1'b1, 4'b0100, 2'd2, "f_cool");
        cyc(1, 1'b1, 4'b0000, 4'b0100, ST_IDLE, 1'b0, 1'b0, 4'b0000, 2'd0, "f_reset_mid");
        cyc(2, 1'b0, 4'b0000, 4'b0100, ST_COOL, 1'b0, 1'b1, 4'b0100, 2'd2, "f_release");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
